// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired control unit for the Mini-SRC datapath. It fetches
//               each instruction, decodes IR[31:27] and drives every datapath
//               control strobe, one state per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'b00001,
    parameter logic [4:0] ALU_SUB = 5'b00010,
    parameter logic [4:0] ALU_AND = 5'b00011,
    parameter logic [4:0] ALU_OR  = 5'b00100
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_Out,
    input  logic        Stop,
    output logic        PCin,
    output logic        IRin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHighin,
    output logic        ZLowin,
    output logic        MARin,
    output logic        MDRin,
    output logic        OutPort,
    output logic        Yin,
    output logic        PCout,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHighout,
    output logic        ZLowout,
    output logic        InPort,
    output logic        MDRout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        CON_In,
    output logic        GLR,
    output logic [4:0]  OP,
    output logic        Run,
    output logic        Illegal
);

    // Instruction opcodes as seen in IR[31:27]
    localparam logic [4:0] c_OPC_LD   = 5'b00000;
    localparam logic [4:0] c_OPC_LDI  = 5'b00001;
    localparam logic [4:0] c_OPC_ST   = 5'b00010;
    localparam logic [4:0] c_OPC_ADD  = 5'b00011;
    localparam logic [4:0] c_OPC_SUB  = 5'b00100;
    localparam logic [4:0] c_OPC_AND  = 5'b01010;
    localparam logic [4:0] c_OPC_OR   = 5'b01011;
    localparam logic [4:0] c_OPC_ADDI = 5'b01100;
    localparam logic [4:0] c_OPC_ANDI = 5'b01101;
    localparam logic [4:0] c_OPC_ORI  = 5'b01110;
    localparam logic [4:0] c_OPC_BR   = 5'b10010;
    localparam logic [4:0] c_OPC_NOP  = 5'b11010;
    localparam logic [4:0] c_OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    state_t     r_state;
    logic [4:0] w_opc;
    logic       w_is_ralu;
    logic       w_is_ialu;
    logic       w_is_ldi;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_is_br;
    logic       w_is_nop;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic [4:0] w_alu_sel;
    logic       w_unused_ir;

    // Only the opcode field matters to the sequencer
    assign w_opc       = IR[31:27];
    assign w_unused_ir = ^IR[26:0];

    assign w_is_ralu = (w_opc == c_OPC_ADD) || (w_opc == c_OPC_SUB) ||
                       (w_opc == c_OPC_AND) || (w_opc == c_OPC_OR);
    assign w_is_ialu = (w_opc == c_OPC_ADDI) || (w_opc == c_OPC_ANDI) ||
                       (w_opc == c_OPC_ORI);
    assign w_is_ldi  = (w_opc == c_OPC_LDI);
    assign w_is_ld   = (w_opc == c_OPC_LD);
    assign w_is_st   = (w_opc == c_OPC_ST);
    assign w_is_br   = (w_opc == c_OPC_BR);
    assign w_is_nop  = (w_opc == c_OPC_NOP);
    assign w_is_halt = (w_opc == c_OPC_HALT);
    assign w_is_illegal = !(w_is_ralu || w_is_ialu || w_is_ldi || w_is_ld ||
                            w_is_st || w_is_br || w_is_nop || w_is_halt);

    // ALU function for the register/immediate ALU ops; everything else adds
    always_comb begin
        w_alu_sel = ALU_ADD;
        case (w_opc)
            c_OPC_SUB:            w_alu_sel = ALU_SUB;
            c_OPC_AND, c_OPC_ANDI: w_alu_sel = ALU_AND;
            c_OPC_OR,  c_OPC_ORI:  w_alu_sel = ALU_OR;
            default:              w_alu_sel = ALU_ADD;
        endcase
    end

    // State sequencing; Clear wins, Stop is honoured only at instruction boundaries
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= S_RST;
        end else begin
            case (r_state)
                S_RST: r_state <= Stop ? S_HALT : S_T0;
                S_T0:  r_state <= S_T1;
                S_T1:  r_state <= S_T2;
                S_T2: begin
                    if (w_is_halt)
                        r_state <= S_HALT;
                    else if (w_is_nop || w_is_illegal)
                        r_state <= Stop ? S_HALT : S_T0;
                    else
                        r_state <= S_T3;
                end
                S_T3:  r_state <= S_T4;
                S_T4:  r_state <= S_T5;
                S_T5: begin
                    if (w_is_ld || w_is_st || w_is_br)
                        r_state <= S_T6;
                    else
                        r_state <= Stop ? S_HALT : S_T0;
                end
                S_T6: begin
                    if (w_is_br)
                        r_state <= Stop ? S_HALT : S_T0;
                    else
                        r_state <= S_T7;
                end
                S_T7:   r_state <= Stop ? S_HALT : S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Strobe decode from the current state and opcode class
    always_comb begin
        PCin    = 1'b0;
        IRin    = 1'b0;
        ZHighin = 1'b0;
        ZLowin  = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        Yin     = 1'b0;
        PCout   = 1'b0;
        ZLowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        IncPC   = 1'b0;
        CON_In  = 1'b0;
        OP      = 5'b00000;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                IncPC = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_br) begin
                    Gra    = 1'b1;
                    Rout   = 1'b1;
                    CON_In = 1'b1;
                end else if (w_is_ralu || w_is_ialu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (w_is_ldi || w_is_ld || w_is_st) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_br) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end else if (w_is_ralu) begin
                    Grc     = 1'b1;
                    Rout    = 1'b1;
                    OP      = w_alu_sel;
                    ZHighin = 1'b1;
                    ZLowin  = 1'b1;
                end else if (w_is_ialu || w_is_ldi || w_is_ld || w_is_st) begin
                    Cout    = 1'b1;
                    OP      = w_alu_sel;
                    ZHighin = 1'b1;
                    ZLowin  = 1'b1;
                end
            end
            S_T5: begin
                if (w_is_br) begin
                    Cout    = 1'b1;
                    OP      = ALU_ADD;
                    ZHighin = 1'b1;
                    ZLowin  = 1'b1;
                end else if (w_is_ld || w_is_st) begin
                    ZLowout = 1'b1;
                    MARin   = 1'b1;
                end else if (w_is_ralu || w_is_ialu || w_is_ldi) begin
                    ZLowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            S_T6: begin
                if (w_is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (w_is_st) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if (w_is_br && CON_Out) begin
                    ZLowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            S_T7: begin
                if (w_is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (w_is_st) begin
                    Write = 1'b1;
                end
            end
            default: begin
                OP = 5'b00000;
            end
        endcase
    end

    // Strobes this sequencer never uses
    assign HIin     = 1'b0;
    assign LOin     = 1'b0;
    assign OutPort  = 1'b0;
    assign HIout    = 1'b0;
    assign LOout    = 1'b0;
    assign ZHighout = 1'b0;
    assign InPort   = 1'b0;
    assign GLR      = 1'b0;

    assign Run     = (r_state != S_HALT);
    assign Illegal = (r_state == S_T2) && w_is_illegal;

endmodule
`default_nettype wire
